// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ACCESS)
//   OWNER_IF / OWNER_D : grant encoding (0 = fetch, 1 = data)
//   req_t : the request bundle latched at grant time
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        sbyte;
  } req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, data requester and memory-side signals of
//   the shared memory port.
//   Handshake: a requester raises *_req with its address/data and keeps it
//   up until it sees its *_ready pulse. *_ready is a single-cycle completion
//   pulse and *_rdata is valid in that cycle, then held until the same
//   requester's next completion. Inputs are sampled only at grant, so
//   changing or dropping a request after it was granted has no effect; the
//   granted access still completes and still pulses ready.
//   Memory side: mem_rd is combinational from mem_addr; the memory writes
//   at the clock edge that ends a cycle with mem_we high (low byte only when
//   mem_sbyte is set).
//   modport slave  : arbiter view
//   modport master : requester + memory view (core / testbench)
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic        d_sbyte;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic        mem_sbyte;
  logic [31:0] mem_rd;

  modport slave (
    input  if_req, if_addr,
    output if_ready, if_rdata,
    input  d_req, d_we, d_sbyte, d_addr, d_wdata,
    output d_ready, d_rdata,
    output mem_addr, mem_wd, mem_we, mem_sbyte,
    input  mem_rd
  );

  modport master (
    output if_req, if_addr,
    input  if_ready, if_rdata,
    output d_req, d_we, d_sbyte, d_addr, d_wdata,
    input  d_ready, d_rdata,
    input  mem_addr, mem_wd, mem_we, mem_sbyte,
    output mem_rd
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin pick.
//   elig[0] = fetch eligible, elig[1] = data eligible
//   last    = previous winner (OWNER_IF / OWNER_D)
//   gnt     = somebody is eligible
//   win     = chosen requester; on a tie the one that did not win last time
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last,
  output logic       gnt,
  output logic       win
);

  always_comb begin
    gnt = |elig;
    win = OWNER_IF;
    if (elig == 2'b11) begin
      win = ~last;
    end else if (elig[1]) begin
      win = OWNER_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch and data
//   load/store. Each access holds the address for WAIT_CYCLES extra cycles,
//   then samples mem_rd (and writes, for a store) in the final ACCESS cycle.
//   Ports:
//     clk, reset_n : clock, synchronous active-low reset
//     bus          : requester + memory signals (slave modport)
//     busy         : high while in ACCESS
//     owner        : current or last grant (0 = fetch, 1 = data)
//     state_dbg    : FSM state
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                owner,
  output arb_state_t          state_dbg
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q;
  req_t             lat_q;
  req_t             sel;
  logic             if_ready_q, d_ready_q;
  logic [31:0]      if_rdata_q, d_rdata_q;
  logic [1:0]       elig;
  logic             gnt_valid, gnt_win;
  logic             do_grant, do_done;

  // A requester whose ready pulse is showing this cycle has just been
  // served; masking it keeps a still-held request from being granted twice.
  assign elig = {bus.d_req  && !d_ready_q,
                 bus.if_req && !if_ready_q};

  rr_arb2 u_rr (
    .elig (elig),
    .last (owner_q),
    .gnt  (gnt_valid),
    .win  (gnt_win)
  );

  // Fetch never writes, so its bundle carries we/sbyte/wdata as zero.
  always_comb begin
    sel = '{addr: bus.if_addr, wdata: 32'h0, we: 1'b0, sbyte: 1'b0};
    if (gnt_win == OWNER_D) begin
      sel = '{addr: bus.d_addr, wdata: bus.d_wdata, we: bus.d_we, sbyte: bus.d_sbyte};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_grant = 1'b0;
    do_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          do_grant = 1'b1;
          cnt_d    = WAIT_LD;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          do_done = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= OWNER_D;  // so fetch wins the first tie
      lat_q      <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if (do_grant) begin
        lat_q   <= sel;
        owner_q <= gnt_win;
      end
      if (do_done) begin
        if (owner_q == OWNER_D) begin
          d_ready_q <= 1'b1;
          d_rdata_q <= bus.mem_rd;
        end else begin
          if_ready_q <= 1'b1;
          if_rdata_q <= bus.mem_rd;
        end
      end
    end
  end

  // Write strobe only in the last ACCESS cycle: exactly one write per store,
  // and it drops as soon as reset returns the FSM to IDLE.
  assign bus.mem_we    = (state_q == ACCESS) && lat_q.we && (cnt_q == '0);
  assign bus.mem_addr  = lat_q.addr;
  assign bus.mem_wd    = lat_q.wdata;
  assign bus.mem_sbyte = lat_q.sbyte;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;

  assign busy      = (state_q == ACCESS);
  assign owner     = owner_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mem_port_arbiter_if b1();
  mem_port_arbiter_if b0();
  logic busy1, owner1, busy0, owner0;
  arb_state_t st1, st0;

  mem_port_arbiter #(.WAIT_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1), .busy(busy1), .owner(owner1), .state_dbg(st1)
  );
  mem_port_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0), .busy(busy0), .owner(owner0), .state_dbg(st0)
  );

  // ---------------- memory models ----------------
  logic [31:0] mem1 [64];
  logic [31:0] mem0 [64];
  assign b1.mem_rd = mem1[b1.mem_addr[7:2]];
  assign b0.mem_rd = mem0[b0.mem_addr[7:2]];

  always @(posedge clk) begin
    if (b1.mem_we) begin
      if (b1.mem_sbyte) mem1[b1.mem_addr[7:2]][7:0] <= b1.mem_wd[7:0];
      else              mem1[b1.mem_addr[7:2]]      <= b1.mem_wd;
    end
    if (b0.mem_we) begin
      if (b0.mem_sbyte) mem0[b0.mem_addr[7:2]][7:0] <= b0.mem_wd[7:0];
      else              mem0[b0.mem_addr[7:2]]      <= b0.mem_wd;
    end
  end

  // ---------------- monitors ----------------
  int   we_cnt1 = 0;
  logic last_sbyte1 = 1'b0;
  always @(negedge clk) begin
    if (b1.mem_we) begin
      we_cnt1++;
      last_sbyte1 = b1.mem_sbyte;
    end
    if (b1.if_ready || b1.d_ready) begin
      total++;
      if (b1.if_ready && b1.d_ready) begin
        bad++;
        $display("FAIL both_ready_w1: if_ready=%0b d_ready=%0b, required not both", b1.if_ready, b1.d_ready);
      end
    end
    if (b0.if_ready || b0.d_ready) begin
      total++;
      if (b0.if_ready && b0.d_ready) begin
        bad++;
        $display("FAIL both_ready_w0: if_ready=%0b d_ready=%0b, required not both", b0.if_ready, b0.d_ready);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_sbyte = 0; b1.d_addr = 0; b1.d_wdata = 0;
    b0.if_req = 0; b0.if_addr = 0; b0.d_req = 0; b0.d_we = 0; b0.d_sbyte = 0; b0.d_addr = 0; b0.d_wdata = 0;
  endtask

  // Leaves the caller in the first cycle after reset release.
  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Issues one data request on the WAIT_CYCLES=1 DUT. lat counts cycles
  // from the request cycle to the ready cycle (-1 on timeout).
  task automatic data_txn(input logic we, input logic sbyte, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    b1.d_req = 1; b1.d_we = we; b1.d_sbyte = sbyte; b1.d_addr = addr; b1.d_wdata = wdata;
    lat = -1;
    rdata = 32'h0;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (b1.d_ready) begin
        lat = k;
        rdata = b1.d_rdata;
      end
      tick();
    end
    b1.d_req = 0;
  endtask

  typedef struct {
    logic        we;
    logic        sbyte;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_we;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin : main
    logic [31:0] rd;
    int lat, we0, n, k;
    int evc[4];
    logic evw[4];
    logic saw;

    idle_inputs();
    for (int i = 0; i < 64; i++) begin
      mem1[i] = 32'h0;
      mem0[i] = 32'h0;
    end
    mem1[0]         = 32'h1111_1111;
    mem1[1]         = 32'h2222_2222;
    mem1[32'h40>>2] = 32'hDEAD_BEEF;
    mem1[32'h80>>2] = 32'hFFFF_FFFF;
    mem1[32'h90>>2] = 32'h8765_4321;
    mem0[0] = 32'hA0A0_A0A0;
    mem0[1] = 32'hB1B1_B1B1;
    mem0[2] = 32'hC2C2_C2C2;
    mem0[3] = 32'hD3D3_D3D3;

    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_if_ready", {31'h0, b1.if_ready}, 32'h0);
    check("rst_d_ready", {31'h0, b1.d_ready}, 32'h0);
    check("rst_if_rdata", b1.if_rdata, 32'h0);
    check("rst_d_rdata", b1.d_rdata, 32'h0);
    check("rst_mem_addr", b1.mem_addr, 32'h0);
    check("rst_mem_wd", b1.mem_wd, 32'h0);
    check("rst_mem_ctl", {30'h0, b1.mem_we, b1.mem_sbyte}, 32'h0);
    check("rst_busy", {31'h0, busy1}, 32'h0);
    check("rst_owner", {31'h0, owner1}, 32'h1);
    check("rst_state", {31'h0, st1}, {31'h0, IDLE});

    // Single load, cycle by cycle
    tick();
    reset_n = 1'b1;
    tick();
    we0 = we_cnt1;
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h40;
    @(negedge clk);
    check("ld_c0_ready", {31'h0, b1.d_ready}, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      tick();
      @(negedge clk);
      check($sformatf("ld_c%0d_addr", c), b1.mem_addr, 32'h40);
      check($sformatf("ld_c%0d_busy_ready", c), {30'h0, busy1, b1.d_ready}, 32'h2);
    end
    tick();
    @(negedge clk);
    check("ld_c3_ready", {31'h0, b1.d_ready}, 32'h1);
    check("ld_c3_rdata", b1.d_rdata, 32'hDEAD_BEEF);
    tick();
    b1.d_req = 0;
    @(negedge clk);
    check("ld_c4_pulse_end", {31'h0, b1.d_ready}, 32'h0);
    check("ld_c4_rdata_held", b1.d_rdata, 32'hDEAD_BEEF);
    check("ld_no_write", we_cnt1 - we0, 0);

    // Table-driven loads and stores
    vecs[0] = '{we: 1, sbyte: 1, addr: 32'h80, wdata: 32'h1234_56AB, exp_rd: 32'hFFFF_FFFF, exp_we: 1};
    vecs[1] = '{we: 0, sbyte: 0, addr: 32'h80, wdata: 32'h0,         exp_rd: 32'hFFFF_FFAB, exp_we: 0};
    vecs[2] = '{we: 1, sbyte: 0, addr: 32'h84, wdata: 32'hCAFE_F00D, exp_rd: 32'h0000_0000, exp_we: 1};
    vecs[3] = '{we: 0, sbyte: 0, addr: 32'h86, wdata: 32'h0,         exp_rd: 32'hCAFE_F00D, exp_we: 0};
    vecs[4] = '{we: 1, sbyte: 1, addr: 32'h85, wdata: 32'h0000_0077, exp_rd: 32'hCAFE_F00D, exp_we: 1};
    vecs[5] = '{we: 0, sbyte: 0, addr: 32'h84, wdata: 32'h0,         exp_rd: 32'hCAFE_F077, exp_we: 0};
    tick();
    for (int i = 0; i < 6; i++) begin
      we0 = we_cnt1;
      exp_q.push_back(vecs[i].exp_rd);
      data_txn(vecs[i].we, vecs[i].sbyte, vecs[i].addr, vecs[i].wdata, rd, lat);
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_rdata", i), rd, exp_q.pop_front());
      check($sformatf("vec%0d_we_cycles", i), we_cnt1 - we0, vecs[i].exp_we);
      if (vecs[i].we) check($sformatf("vec%0d_sbyte", i), {31'h0, last_sbyte1}, {31'h0, vecs[i].sbyte});
    end

    // Contention from the first cycle after reset: F, D, F, D
    do_reset();
    b1.if_req = 1; b1.if_addr = 32'h0;
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h40;
    n = 0;
    for (k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (b1.if_ready) begin
        evw[n] = 1'b0; evc[n] = k; n++;
        check("cont_if_rdata", b1.if_rdata, 32'h1111_1111);
      end else if (b1.d_ready) begin
        evw[n] = 1'b1; evc[n] = k; n++;
        check("cont_d_rdata", b1.d_rdata, 32'hDEAD_BEEF);
      end
      tick();
    end
    b1.if_req = 0; b1.d_req = 0;
    check("cont_events", n, 4);
    for (int i = 0; i < n; i++) begin
      check($sformatf("cont_winner%0d", i), {31'h0, evw[i]}, {31'h0, i[0]});
      check($sformatf("cont_cycle%0d", i), evc[i], 3 + 3 * i);
    end
    // A fetch was granted in the last data-ready cycle; dropping the
    // request must not cancel it.
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b1.if_ready) saw = 1'b1;
      tick();
    end
    check("dropped_req_completes", {31'h0, saw}, 32'h1);

    // Ready masking: fetch held through its ready cycle
    do_reset();
    b1.if_req = 1; b1.if_addr = 32'h4;
    saw = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      @(negedge clk);
      if (b1.if_ready) begin
        saw = 1'b1;
        check("mask_if_rdata", b1.if_rdata, 32'h2222_2222);
      end
      tick();
    end
    check("mask_ready_seen", {31'h0, saw}, 32'h1);
    b1.if_req = 0;
    @(negedge clk);
    check("mask_no_regrant", {31'h0, busy1}, 32'h0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (b1.if_ready) n++;
      tick();
      @(negedge clk);
    end
    check("mask_no_dup_ready", n, 0);

    // Reset during the first wait cycle of a store
    do_reset();
    we0 = we_cnt1;
    b1.d_req = 1; b1.d_we = 1; b1.d_sbyte = 0; b1.d_addr = 32'h90; b1.d_wdata = 32'h55AA_55AA;
    tick();
    @(negedge clk);
    check("abort_in_access", {30'h0, busy1, b1.mem_we}, 32'h2);
    reset_n = 1'b0;
    b1.d_req = 0;
    tick();
    @(negedge clk);
    check("abort_outs_zero", {b1.if_ready, b1.d_ready, b1.mem_we, b1.mem_sbyte, busy1}, 32'h0);
    check("abort_mem_addr", b1.mem_addr, 32'h0);
    check("abort_rdata", b1.d_rdata, 32'h0);
    check("abort_owner", {31'h0, owner1}, 32'h1);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      if (b1.d_ready) n++;
    end
    check("abort_no_ready", n, 0);
    check("abort_no_write", we_cnt1 - we0, 0);
    check("abort_word_kept", mem1[32'h90>>2], 32'h8765_4321);

    // WAIT_CYCLES = 0: back-to-back fetches 0x0, 0x4, 0x8
    tick();
    b0.if_req = 1; b0.if_addr = 32'h0;
    n = 0;
    for (k = 0; k < 30 && n < 3; k++) begin
      @(negedge clk);
      if (b0.if_ready) begin
        check($sformatf("w0_fetch%0d_rdata", n), b0.if_rdata, mem0[n]);
        evc[n] = k; n++;
      end
      tick();
      b0.if_addr = 32'(n * 4);
    end
    b0.if_req = 0;
    check("w0_fetch_events", n, 3);
    for (int i = 0; i < n; i++) check($sformatf("w0_fetch%0d_cycle", i), evc[i], 2 + 3 * i);

    // WAIT_CYCLES = 0 contention: last owner was fetch, so data goes first
    tick();
    b0.if_req = 1; b0.if_addr = 32'h0;
    b0.d_req = 1; b0.d_we = 0; b0.d_addr = 32'hC;
    n = 0;
    for (k = 0; k < 30 && n < 4; k++) begin
      @(negedge clk);
      if (b0.d_ready) begin
        evw[n] = 1'b1; evc[n] = k; n++;
        check("w0_cont_d_rdata", b0.d_rdata, 32'hD3D3_D3D3);
      end else if (b0.if_ready) begin
        evw[n] = 1'b0; evc[n] = k; n++;
        check("w0_cont_if_rdata", b0.if_rdata, 32'hA0A0_A0A0);
      end
      tick();
    end
    b0.if_req = 0; b0.d_req = 0;
    check("w0_cont_events", n, 4);
    for (int i = 0; i < n; i++) begin
      check($sformatf("w0_cont_winner%0d", i), {31'h0, evw[i]}, {31'h0, ~i[0]});
      check($sformatf("w0_cont_cycle%0d", i), evc[i], 2 + 2 * i);
    end
    repeat (4) tick();

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
